btn_pulse_gen: RTL and testbench
================================

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_N, default 1000000, meaning the number of stable clock cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter REPEAT_N, default 50000000, meaning the auto-repeat period in cycles (0.5 s at 100 MHz).
REQ-003 The block SHALL have port CLK_100mhz, input, width 1: 100 MHz system clock; it is the only clock.
REQ-004 The block SHALL have port rst_n, input, width 1: synchronous, active-low reset.
REQ-005 The block SHALL have port btn_in, input, width 1: raw asynchronous push-button level, active-high, bouncing.
REQ-006 The block SHALL have port btn_level, output, width 1: debounced button level.
REQ-007 The block SHALL have port step_pulse, output, width 1: single-cycle step strobe for the single-step CPU clock-enable.
REQ-008 The block SHALL have port press_cnt, output, width 16: count of step_pulse strobes issued.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer before any other use; all later logic SHALL use only the synchronized value (sync).
REQ-010 The FSM SHALL have four states: IDLE, PRESS_CHK, HELD and REL_CHK. The debounce counter SHALL be 32 bits wide.
REQ-011 In IDLE, sync=1 SHALL cause a transition to PRESS_CHK with the counter cleared to 0.
REQ-012 In PRESS_CHK, sync=0 SHALL cause a return to IDLE. Otherwise, at counter==DEBOUNCE_N-1 the FSM SHALL go to HELD and set step_pulse; otherwise the counter SHALL increment.
REQ-013 In HELD, sync=0 SHALL cause a transition to REL_CHK with the counter cleared to 0.
REQ-014 In REL_CHK, sync=1 SHALL cause a return to HELD with no pulse. Otherwise, at counter==DEBOUNCE_N-1 the FSM SHALL go to IDLE; otherwise the counter SHALL increment.
REQ-015 step_pulse SHALL be registered, SHALL stay high for exactly one cycle per accepted press, and SHALL NOT fire on release.
REQ-016 Latency: with btn_in held high, step_pulse SHALL be high in cycle DEBOUNCE_N+2, counting the clock edge that first samples btn_in=1 as edge 0.
REQ-017 btn_level SHALL be 1 in HELD and REL_CHK, and 0 in IDLE and PRESS_CHK.
REQ-018 press_cnt SHALL increment in the same cycle step_pulse is high, and SHALL wrap from 0xFFFF to 0x0000.
REQ-019 A bounce that is shorter than DEBOUNCE_N cycles, in either direction, SHALL produce no pulse and no change of btn_level.

Reset
REQ-020 While rst_n=0 at a clock edge, the block SHALL set: FSM=IDLE, both synchronizer flops=0, all counters=0, step_pulse=0, btn_level=0, press_cnt=0.
REQ-021 Reset asserted mid-press, in any state, SHALL abort without emitting a pulse. If the button is still held after release of reset, it SHALL be debounced afresh as a new press.

Configuration
REQ-022 Macro BTN_AUTO_REPEAT_EN defined: in HELD and REL_CHK, a 32-bit repeat counter SHALL run and emit an additional step_pulse (and press_cnt increment) every REPEAT_N cycles. The repeat counter SHALL be cleared on entry to HELD from PRESS_CHK and on entry to IDLE, and SHALL be preserved across a REL_CHK->HELD bounce.
REQ-023 Macro BTN_AUTO_REPEAT_EN undefined: there SHALL be no repeat counter, REPEAT_N SHALL be ignored, and the block SHALL emit exactly one pulse per debounced press.

Structure
REQ-024 Package cpu_io_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, PRESS_CHK=1, HELD=2, REL_CHK=3) and the default DEBOUNCE_N and REPEAT_N constants.
REQ-025 The synchronizer SHALL be a sub-module named sync_2ff, with ports clock, reset and data in/out, reusable by the other I/O blocks.

Verification (bench uses DEBOUNCE_N=4, REPEAT_N=20)
REQ-026 Clean press: btn_in 0->1, held for 30 cycles -> step_pulse high only in cycle 6, btn_level=1 from cycle 6, press_cnt=1.
REQ-027 Bounce rejection: btn_in pulses 1 for 2 cycles, then 0, repeated 5 times -> step_pulse never asserts, btn_level stays 0, press_cnt=0.
REQ-028 Release bounce: in HELD, btn_in drops for 2 cycles then returns high -> btn_level stays 1 and no second pulse occurs. A final drop held 10 cycles -> btn_level=0 six cycles after the drop.
REQ-029 Reset mid-operation: rst_n=0 for 1 cycle while in PRESS_CHK with counter=2 -> no pulse. With btn_in still held, a pulse SHALL occur 6 cycles after rst_n returns to 1.
REQ-030 Wrap: press_cnt preloaded by 65535 presses (or forced) plus one more press -> press_cnt=0x0000.
REQ-031 Auto-repeat (BTN_AUTO_REPEAT_EN defined): hold btn_in for 70 cycles -> pulses in cycles 6, 26, 46 and 66, press_cnt=4. With the macro undefined, the same stimulus -> a single pulse in cycle 6.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared types and default timing constants for the CPU front-panel I/O blocks
package cpu_io_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_e;

    // 10 ms of stable level at 100 MHz before a change is accepted
    localparam int unsigned BTN_DEBOUNCE_N_DEFAULT = 32'd1000000;
    // 0.5 s auto-repeat period at 100 MHz
    localparam int unsigned BTN_REPEAT_N_DEFAULT   = 32'd50000000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - debounced push-button to single-step strobe; BTN_AUTO_REPEAT_EN adds hold-to-repeat
module btn_pulse_gen
    import cpu_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = BTN_DEBOUNCE_N_DEFAULT,
    parameter int unsigned REPEAT_N   = BTN_REPEAT_N_DEFAULT
) (
    input  logic        CLK_100mhz,
    input  logic        rst_n,
    input  logic        btn_in,
    output logic        btn_level,
    output logic        step_pulse,
    output logic [15:0] press_cnt
);

    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_N - 32'd1);

    btn_state_e  state_q, state_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic        step_q, step_d;
    logic [15:0] press_cnt_q, press_cnt_d;
    logic        press_accept;
    logic        btn_sync;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk_i  (CLK_100mhz),
        .rst_ni (rst_n),
        .d_i    (btn_in),
        .q_o    (btn_sync)
    );

    // Debounce FSM: a level change is accepted only after DEBOUNCE_N stable cycles
    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        press_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d      = HELD;
                    press_accept = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 32'd1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_d  = REL_CHK;
                    db_cnt_d = '0;
                end
            end
            REL_CHK: begin
                if (btn_sync) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [31:0] RP_LAST = 32'(REPEAT_N - 32'd1);

    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic        rep_fire;

    // Repeat timer runs while the button is considered down; a release glitch keeps its phase
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        if (press_accept || (state_d == IDLE)) begin
            rep_cnt_d = '0;
        end else if ((state_q == HELD) || (state_q == REL_CHK)) begin
            if (rep_cnt_q == RP_LAST) begin
                rep_fire  = 1'b1;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 32'd1;
            end
        end
    end

    // Repeat timer register
    always_ff @(posedge CLK_100mhz) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign step_d = press_accept | rep_fire;
`else
    logic unused_repeat_n;
    assign unused_repeat_n = ^REPEAT_N;

    assign step_d = press_accept;
`endif

    assign press_cnt_d = step_d ? (press_cnt_q + 16'd1) : press_cnt_q;

    // State, debounce counter, registered strobe and wrapping strobe count
    always_ff @(posedge CLK_100mhz) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            step_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            step_q      <= step_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign btn_level  = (state_q == HELD) || (state_q == REL_CHK);
    assign step_pulse = step_q;
    assign press_cnt  = press_cnt_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb/tb_btn_pulse_gen.sv - table-driven scoreboard bench for btn_pulse_gen
module tb_btn_pulse_gen;

    localparam int DB = 4;
    localparam int RP = 20;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        btn;
        logic        poke;
        logic        pulse;
        logic        level;
        logic [15:0] cnt;
        string       tag;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        btn_in;
    logic        btn_level;
    logic        step_pulse;
    logic [15:0] press_cnt;

    vec_t        vecs[$];
    vec_t        sb[$];
    vec_t        exp_v;
    logic [15:0] exp_cnt;
    int          total;
    int          bad;

    btn_pulse_gen #(
        .DEBOUNCE_N (DB),
        .REPEAT_N   (RP)
    ) dut (
        .CLK_100mhz (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .step_pulse (step_pulse),
        .press_cnt  (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic btn, input logic pulse,
                                input logic level, input string tag);
        vec_t v;
        if (!rst) exp_cnt = 16'h0000;
        else if (pulse) exp_cnt = exp_cnt + 16'd1;
        v.rst = rst; v.btn = btn; v.poke = 1'b0;
        v.pulse = pulse; v.level = level; v.cnt = exp_cnt; v.tag = tag;
        vecs.push_back(v);
    endfunction

    function automatic void add_poke(input string tag);
        vec_t v;
        exp_cnt = 16'hFFFF;
        v.rst = 1'b1; v.btn = 1'b0; v.poke = 1'b1;
        v.pulse = 1'b0; v.level = 1'b0; v.cnt = exp_cnt; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Press held for 'hold' cycles then released for 'rel' cycles, starting from IDLE
    function automatic void press(input int hold, input int rel, input string tag);
        for (int t = 0; t < hold + rel; t++) begin
            logic p;
            logic l;
            p = (t == DB + 2) ||
                (REP_EN && (t > DB + 2) && (((t - (DB + 2)) % RP) == 0) && (t < hold + DB + 2));
            l = (t >= DB + 2) && (t < hold + DB + 2);
            add(1'b1, (t < hold), p, l, tag);
        end
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] got,
                       input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, want);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_in  = 1'b0;
        total   = 0;
        bad     = 0;
        exp_cnt = 16'h0000;

        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, "reset");
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, "idle");
        press(30, 10, "clean");
        for (int r = 0; r < 5; r++) begin
            add(1'b1, 1'b1, 1'b0, 1'b0, "bounce");
            add(1'b1, 1'b1, 1'b0, 1'b0, "bounce");
            add(1'b1, 1'b0, 1'b0, 1'b0, "bounce");
            add(1'b1, 1'b0, 1'b0, 1'b0, "bounce");
        end
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, 1'b0, "bounce_tail");
        for (int t = 0; t < 28; t++) begin
            logic b;
            b = (t < 12) || ((t >= 14) && (t < 18));
            add(1'b1, b, (t == 6), ((t >= 6) && (t < 24)), "rel_bounce");
        end
        for (int t = 0; t < 5; t++) add(1'b1, 1'b1, 1'b0, 1'b0, "mid_press");
        add(1'b0, 1'b1, 1'b0, 1'b0, "mid_reset");
        press(10, 10, "rst_recover");
        press(70, 10, "repeat");
        add_poke("preload");
        press(10, 10, "wrap");
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, "final");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].poke) begin
                force dut.press_cnt_q = 16'hFFFF;
                #1;
                release dut.press_cnt_q;
            end
            rst_n  = vecs[i].rst;
            btn_in = vecs[i].btn;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            chk({exp_v.tag, ".pulse"}, i, {15'd0, step_pulse}, {15'd0, exp_v.pulse});
            chk({exp_v.tag, ".level"}, i, {15'd0, btn_level},  {15'd0, exp_v.level});
            chk({exp_v.tag, ".cnt"},   i, press_cnt,           exp_v.cnt);
        end

        chk("wrap_final", vecs.size(), press_cnt, 16'h0001 - 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
